// File: rtl/iotdf_job_sched.sv
// Round-robin job scheduler for the IoT data filter. Fetches the winning
// requester's frame record by record and streams it byte-serially to the filter.
//   state   | meaning
//   S_IDLE  | arbitrate; the grant cycle also reads record 0
//   S_LOAD  | record 0 enters the shift register, prefetch record 1
//   S_SEND  | one byte per non-busy cycle, next record prefetched
//   S_DRAIN | wait DRAIN_CYC cycles for late filter results
//   S_DONE  | job_done pulse with the result count
module iotdf_job_sched #(
  parameter int REC_PER_JOB   = 96,
  parameter int BYTES_PER_REC = 16,
  parameter int DRAIN_CYC     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   i_req,
  input  logic [5:0]   i_req_fn,
  output logic [1:0]   o_gnt,
  output logic         o_mem_rd,
  output logic         o_mem_sel,
  output logic [6:0]   o_mem_addr,
  input  logic [127:0] i_mem_data,
  output logic         o_f_in_en,
  output logic [7:0]   o_f_iot_in,
  output logic [2:0]   o_f_fn_sel,
  input  logic         i_f_busy,
  input  logic         i_f_valid,
  input  logic [127:0] i_f_iot_out,
  output logic         o_res_valid,
  output logic [127:0] o_res_data,
  output logic         o_res_tag,
  output logic         o_job_done,
  output logic [6:0]   o_res_cnt
);

  localparam int BW = $clog2(BYTES_PER_REC);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam logic [6:0]    LAST_REC  = 7'(REC_PER_JOB - 1);
  localparam logic [7:0]    LAST_REC8 = 8'(REC_PER_JOB - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES_PER_REC - 1);
  localparam logic [6:0]    RES_MAX   = 7'(REC_PER_JOB);
  localparam logic [DW-1:0] DRAIN_TC  = DW'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_DRAIN, S_DONE} state_t;

  state_t          r_state, w_next;
  logic            r_last;
  logic            r_owner;
  logic [2:0]      r_fn;
  logic [127:0]    r_shift;
  logic [127:0]    r_next;
  logic [BW-1:0]   r_byte;
  logic [6:0]      r_rec;
  logic [DW-1:0]   r_drain;
  logic            r_rd_pend;
  logic [6:0]      r_res_cnt;
  logic            r_res_valid;
  logic [127:0]    r_res_data;
  logic            r_res_tag;

  logic       w_elig0, w_elig1, w_win, w_win_owner;
  logic [2:0] w_win_fn;
  logic       w_send, w_rec_end, w_prefetch, w_res_win;

  assign w_elig0     = i_req[0] & (i_req_fn[2:0] != 3'd0);
  assign w_elig1     = i_req[1] & (i_req_fn[5:3] != 3'd0);
  // Gated by rst so the combinational grant path is quiet while in reset.
  assign w_win       = (w_elig0 | w_elig1) & ~rst & (r_state == S_IDLE);
  assign w_win_owner = (w_elig0 & w_elig1) ? ~r_last : w_elig1;
  assign w_win_fn    = w_win_owner ? i_req_fn[5:3] : i_req_fn[2:0];
  assign w_send      = (r_state == S_SEND) & ~i_f_busy;
  assign w_rec_end   = w_send & (r_byte == LAST_BYTE);
  assign w_prefetch  = w_rec_end & (({1'b0, r_rec} + 8'd2) <= LAST_REC8);
  assign w_res_win   = (r_state == S_SEND) | (r_state == S_DRAIN) | (r_state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_win) w_next = S_LOAD;
      S_LOAD:  w_next = S_SEND;
      S_SEND:  if (w_rec_end && r_rec == LAST_REC) w_next = S_DRAIN;
      S_DRAIN: if (r_drain == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_gnt      = 2'b00;
    o_mem_rd   = 1'b0;
    o_mem_sel  = 1'b0;
    o_mem_addr = 7'd0;
    o_f_in_en  = 1'b0;
    o_f_iot_in = 8'd0;
    o_f_fn_sel = 3'd0;
    o_job_done = 1'b0;
    o_res_cnt  = 7'd0;
    case (r_state)
      S_IDLE: begin
        if (w_win) begin
          o_gnt      = w_win_owner ? 2'b10 : 2'b01;
          o_mem_rd   = 1'b1;
          o_mem_sel  = w_win_owner;
          o_f_fn_sel = w_win_fn;
        end
      end
      S_LOAD: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = 7'd1;
        o_mem_sel  = r_owner;
        o_f_fn_sel = r_fn;
      end
      S_SEND: begin
        o_mem_sel  = r_owner;
        o_f_fn_sel = r_fn;
        o_f_in_en  = w_send;
        o_f_iot_in = w_send ? r_shift[127:120] : 8'd0;
        o_mem_rd   = w_prefetch;
        o_mem_addr = w_prefetch ? (r_rec + 7'd2) : 7'd0;
      end
      S_DRAIN: begin
        o_mem_sel  = r_owner;
        o_f_fn_sel = r_fn;
      end
      S_DONE: begin
        o_mem_sel  = r_owner;
        o_f_fn_sel = r_fn;
        o_job_done = 1'b1;
        o_res_cnt  = r_res_cnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_fn      <= 3'd0;
      r_shift   <= '0;
      r_next    <= '0;
      r_byte    <= '0;
      r_rec     <= 7'd0;
      r_drain   <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= o_mem_rd;
      // Read data for the prefetched record lands one cycle after the strobe.
      if (r_rd_pend && r_state == S_SEND) r_next <= i_mem_data;
      case (r_state)
        S_IDLE: begin
          if (w_win) begin
            r_owner <= w_win_owner;
            r_fn    <= w_win_fn;
            r_rec   <= 7'd0;
            r_byte  <= '0;
          end
        end
        S_LOAD: r_shift <= i_mem_data;
        S_SEND: begin
          if (w_send) begin
            if (w_rec_end) begin
              r_shift <= r_next;
              r_byte  <= '0;
              r_rec   <= r_rec + 7'd1;
            end else begin
              r_shift <= {r_shift[119:0], 8'd0};
              r_byte  <= r_byte + 1'b1;
            end
          end
          if (w_next == S_DRAIN) r_drain <= DRAIN_TC;
        end
        S_DRAIN: if (r_drain != '0) r_drain <= r_drain - 1'b1;
        S_DONE:  r_last <= r_owner;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_tag   <= 1'b0;
      r_res_cnt   <= 7'd0;
    end else begin
      r_res_valid <= i_f_valid & w_res_win;
      if (w_win) r_res_cnt <= 7'd0;
      else if (i_f_valid && w_res_win) begin
        r_res_data <= i_f_iot_out;
        r_res_tag  <= r_owner;
        if (r_res_cnt != RES_MAX) r_res_cnt <= r_res_cnt + 7'd1;
      end
    end
  end

  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_res_tag   = r_res_tag;

endmodule
